cndm_stat_accum: RTL and testbench

// - Statistics accumulator that consumes the MAC statistics increment stream (16-bit increment, 8-bit counter ID).
// - Adds each increment into a per-ID wide counter held in block RAM.
// - Exposes a req/ack read port with optional clear-on-read for the driver register block.
// - Sits directly downstream of the MAC stat output, in the stat clock domain.

---
 rtl/cndm_stat_accum.sv | 218 +++++++++++++++++++++
 tb/tb_cndm_stat_accum.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cndm_stat_accum.sv
// Per-ID statistics accumulator: RAM-backed wide counters fed by a stat stream,
// with a drained req/ack read port that can clear the counter it returns.
module cndm_stat_accum #(
  parameter int INC_W = 16,
  parameter int ID_W  = 8,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INC_W-1:0] s_axis_stat_tdata,
  input  logic [ID_W-1:0]  s_axis_stat_tid,
  input  logic             s_axis_stat_tuser,
  input  logic             s_axis_stat_tvalid,
  output logic             s_axis_stat_tready,
  input  logic             rd_req,
  input  logic [ID_W-1:0]  rd_addr,
  input  logic             rd_clr,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic             init_busy
);

  localparam int DEPTH = 2**ID_W;
  localparam logic [ID_W-1:0] ID_MAX = '1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } st_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_DRAIN,
    R_RD,
    R_WAIT,
    R_RESP
  } rs_t;

  st_t              r_st;
  rs_t              r_rs;
  logic             r_busy;
  logic [ID_W-1:0]  r_init_ptr;
  logic [ID_W-1:0]  r_rd_addr;
  logic             r_rd_clr;
  logic             r_ack;
  logic [CNT_W-1:0] r_rd_data;

  logic             r_v1;
  logic [ID_W-1:0]  r_id1;
  logic [INC_W-1:0] r_inc1;
  logic             r_usr1;

  logic             r_v2;
  logic [ID_W-1:0]  r_id2;
  logic [INC_W-1:0] r_inc2;
  logic             r_usr2;
  logic [CNT_W-1:0] r_old2;

  logic             r_wb_v;
  logic [ID_W-1:0]  r_wb_id;
  logic [CNT_W-1:0] r_wb_data;

  logic [CNT_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_ram_q;

  logic             w_tready;
  logic             w_acc;
  logic [CNT_W-1:0] w_inc2_ext;
  logic [CNT_W-1:0] w_new;
  logic [CNT_W-1:0] w_old1;
  logic             w_we;
  logic [ID_W-1:0]  w_waddr;
  logic [CNT_W-1:0] w_wdata;
  logic [ID_W-1:0]  w_raddr;

  assign w_tready = (r_st == ST_RUN) && (r_rs == R_IDLE);
  assign w_acc    = s_axis_stat_tvalid && w_tready;

  assign s_axis_stat_tready = w_tready;
  assign rd_ack             = r_ack;
  assign rd_data            = r_rd_data;
  assign init_busy          = r_busy;

  assign w_inc2_ext = {{(CNT_W-INC_W){1'b0}}, r_inc2};
  assign w_new      = r_usr2 ? w_inc2_ext
                             : r_old2 + w_inc2_ext;

  // S2 result wins, then the entry written last cycle (its
  // RAM write raced the S1 read), then the RAM itself.
  always_comb begin
    w_old1 = r_ram_q;
    if (r_v2 && (r_id2 == r_id1)) begin
      w_old1 = w_new;
    end else if (r_wb_v && (r_wb_id == r_id1)) begin
      w_old1 = r_wb_data;
    end
  end

  assign w_raddr = (r_rs == R_RD) ? r_rd_addr
                                  : s_axis_stat_tid;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_init_ptr;
    w_wdata = '0;
    unique case (1'b1)
      (r_st == ST_INIT): begin
        w_we    = 1'b1;
        w_waddr = r_init_ptr;
      end
      r_v2: begin
        w_we    = 1'b1;
        w_waddr = r_id2;
        w_wdata = w_new;
      end
      (r_rs == R_RESP && r_rd_clr): begin
        w_we    = 1'b1;
        w_waddr = r_rd_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
    r_ram_q <= r_mem[w_raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1      <= 1'b0;
      r_id1     <= '0;
      r_inc1    <= '0;
      r_usr1    <= 1'b0;
      r_v2      <= 1'b0;
      r_id2     <= '0;
      r_inc2    <= '0;
      r_usr2    <= 1'b0;
      r_old2    <= '0;
      r_wb_v    <= 1'b0;
      r_wb_id   <= '0;
      r_wb_data <= '0;
    end else begin
      r_v1 <= w_acc;
      if (w_acc) begin
        r_id1  <= s_axis_stat_tid;
        r_inc1 <= s_axis_stat_tdata;
        r_usr1 <= s_axis_stat_tuser;
      end
      r_v2      <= r_v1;
      r_id2     <= r_id1;
      r_inc2    <= r_inc1;
      r_usr2    <= r_usr1;
      r_old2    <= w_old1;
      r_wb_v    <= r_v2;
      r_wb_id   <= r_id2;
      r_wb_data <= w_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st       <= ST_INIT;
      r_busy     <= 1'b1;
      r_init_ptr <= '0;
      r_rs       <= R_IDLE;
      r_rd_addr  <= '0;
      r_rd_clr   <= 1'b0;
      r_ack      <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_ack <= 1'b0;

      unique case (r_st)
        ST_INIT: begin
          r_init_ptr <= r_init_ptr + 1'b1;
          if (r_init_ptr == ID_MAX) begin
            r_st   <= ST_RUN;
            r_busy <= 1'b0;
          end
        end
        ST_RUN: ;
      endcase

      unique case (r_rs)
        R_IDLE: begin
          if (r_st == ST_RUN && rd_req) begin
            r_rd_addr <= rd_addr;
            r_rd_clr  <= rd_clr;
            r_rs      <= R_DRAIN;
          end
        end
        R_DRAIN: begin
          if (!r_v1 && !r_v2) begin
            r_rs <= R_RD;
          end
        end
        R_RD: begin
          r_rs <= R_WAIT;
        end
        R_WAIT: begin
          r_ack     <= 1'b1;
          r_rd_data <= r_ram_q;
          r_rs      <= R_RESP;
        end
        R_RESP: begin
          r_rs <= R_IDLE;
        end
        default: begin
          r_rs <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cndm_stat_accum.sv
// Randomized bench for cndm_stat_accum against a per-ID sum model.
// Narrow counters make the wrap reachable in a short run.
module tb_cndm_stat_accum;

  localparam int INC_W = 16;
  localparam int ID_W  = 8;
  localparam int CNT_W = 20;
  localparam longint unsigned MASK = (64'd1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [INC_W-1:0] tdata;
  logic [ID_W-1:0]  tid;
  logic             tuser;
  logic             tvalid;
  logic             tready;
  logic             rd_req;
  logic [ID_W-1:0]  rd_addr;
  logic             rd_clr;
  logic             rd_ack;
  logic [CNT_W-1:0] rd_data;
  logic             init_busy;

  cndm_stat_accum #(
    .INC_W(INC_W),
    .ID_W (ID_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis_stat_tdata (tdata),
    .s_axis_stat_tid   (tid),
    .s_axis_stat_tuser (tuser),
    .s_axis_stat_tvalid(tvalid),
    .s_axis_stat_tready(tready),
    .rd_req            (rd_req),
    .rd_addr           (rd_addr),
    .rd_clr            (rd_clr),
    .rd_ack            (rd_ack),
    .rd_data           (rd_data),
    .init_busy         (init_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  longint unsigned model [256];
  longint unsigned exp_q [$];
  bit acc;
  bit racc;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: check any ack, drive at negedge, update the model
  // for whatever the handshake will accept on the next posedge.
  task automatic tick(input bit v, input logic [7:0] id,
                      input logic [15:0] d, input bit u,
                      input bit rq, input logic [7:0] ra,
                      input bit rc);
    longint unsigned e;
    @(negedge clk);
    if (rd_ack) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        chk("extra_ack", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", 64'(rd_data), e);
      end
    end
    tvalid  = v;
    tid     = id;
    tdata   = d;
    tuser   = u;
    rd_req  = rq;
    rd_addr = ra;
    rd_clr  = rc;
    acc  = v && tready;
    racc = rq && tready;
    if (acc) begin
      if (u) model[id] = longint'(d);
      else   model[id] = (model[id] + longint'(d)) & MASK;
    end
    if (racc) begin
      exp_q.push_back(model[ra]);
      if (rc) model[ra] = 0;
    end
  endtask

  task automatic idle();
    tick(0, 8'd0, 16'd0, 0, 0, 8'd0, 0);
  endtask

  task automatic beat(input logic [7:0] id,
                      input logic [15:0] d, input bit u);
    tick(1, id, d, u, 0, 8'd0, 0);
    chk("beat_acc", acc, 1);
  endtask

  task automatic do_read(input logic [7:0] a, input bit c,
                         input bit v, input logic [15:0] d,
                         output int lat);
    int n;
    n = ack_cnt;
    tick(v, a, d, 0, 1, a, c);
    chk("rd_accepted", racc, 1);
    lat = 0;
    while (ack_cnt == n && lat < 16) begin
      idle();
      lat++;
      if (lat == 1) chk("tready_drop", tready, 0);
    end
    if (ack_cnt == n) chk("rd_timeout", 0, 1);
  endtask

  task automatic init_seq();
    int cnt;
    bit saw;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tready", tready, 0);
    chk("rst_ack", rd_ack, 0);
    chk("rst_data", 64'(rd_data), 0);
    chk("rst_busy", init_busy, 1);
    rd_req  = 1'b1;
    rd_addr = 8'd0;
    rst_n   = 1'b1;
    cnt = 0;
    saw = 0;
    while (init_busy && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
      if (rd_ack) saw = 1;
    end
    rd_req = 1'b0;
    chk("init_cycles", cnt, 256);
    chk("init_no_ack", saw, 0);
    for (int i = 0; i < 256; i++) model[i] = 0;
    exp_q.delete();
  endtask

  task automatic read_all();
    int lat;
    for (int i = 0; i < 256; i++) begin
      do_read(8'(i), 0, 0, 16'd0, lat);
    end
  endtask

  task automatic random_run(input int cycles);
    logic [7:0]  id;
    logic [15:0] d;
    bit u, v, rq, rc;
    logic [7:0] ra;
    id = 8'd0; d = 16'd0; u = 0;
    for (int i = 0; i < cycles; i++) begin
      if (i == 0 || acc) begin
        id = ($urandom % 4 == 0) ? 8'($urandom % 256)
                                 : 8'($urandom % 4);
        d  = ($urandom % 8 == 0) ? 16'hFFFF
                                 : 16'($urandom % 65536);
        u  = ($urandom % 32 == 0);
      end
      v  = ($urandom % 8 != 0);
      rq = ($urandom % 12 == 0);
      ra = ($urandom % 2 == 0) ? 8'($urandom % 4)
                               : 8'($urandom % 256);
      rc = ($urandom % 6 == 0);
      tick(v, id, d, u, rq, ra, rc);
    end
  endtask

  initial begin
    int lat;
    int n;
    rst_n  = 1'b0;
    tvalid = 1'b0;
    tdata  = '0;
    tid    = '0;
    tuser  = 1'b0;
    rd_req = 1'b0;
    rd_addr = '0;
    rd_clr = 1'b0;

    init_seq();
    repeat (3) idle();
    do_read(8'd0, 0, 0, 16'd0, lat);
    chk("lat_empty", lat, 4);
    chk("zero_after_init", 64'(rd_data), 0);
    idle();
    chk("tready_back", tready, 1);

    beat(8'd5, 16'd1, 0);
    beat(8'd5, 16'd2, 0);
    beat(8'd5, 16'd3, 0);
    do_read(8'd5, 0, 0, 16'd0, lat);
    chk("id5_sum", 64'(rd_data), 6);
    chk("lat_drain", (lat <= 6), 1);

    beat(8'd7, 16'd55, 0);
    beat(8'd7, 16'd100, 1);
    beat(8'd7, 16'd1, 0);
    do_read(8'd7, 0, 0, 16'd0, lat);
    chk("id7_set", 64'(rd_data), 101);

    for (int i = 0; i < 16; i++) beat(8'd9, 16'hFFFF, 0);
    beat(8'd9, 16'd15, 0);
    do_read(8'd9, 0, 0, 16'd0, lat);
    chk("id9_full", 64'(rd_data), 64'hFFFFF);
    beat(8'd9, 16'd2, 0);
    do_read(8'd9, 0, 0, 16'd0, lat);
    chk("id9_wrap", 64'(rd_data), 1);

    beat(8'd3, 16'd10, 0);
    do_read(8'd3, 1, 0, 16'd0, lat);
    chk("id3_clr_val", 64'(rd_data), 10);
    do_read(8'd3, 0, 0, 16'd0, lat);
    chk("id3_after_clr", 64'(rd_data), 0);

    beat(8'd3, 16'd4, 0);
    n = ack_cnt;
    tick(0, 8'd0, 16'd0, 0, 1, 8'd3, 0);
    idle();
    tick(0, 8'd0, 16'd0, 0, 1, 8'd3, 0);
    repeat (10) idle();
    chk("one_ack", ack_cnt - n, 1);
    chk("id3_dbl_val", 64'(rd_data), 4);

    do_read(8'd20, 0, 1, 16'd7, lat);
    chk("same_cyc_val", 64'(rd_data), 7);
    chk("lat_same_cyc", lat, 6);

    // forwarding distance 1 and 2 in a tight pattern
    beat(8'd30, 16'd1, 0);
    beat(8'd31, 16'd2, 0);
    beat(8'd30, 16'd4, 0);
    beat(8'd30, 16'd8, 0);
    do_read(8'd30, 0, 0, 16'd0, lat);
    chk("fwd_mix", 64'(rd_data), 13);

    random_run(2500);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      idle();
      n++;
    end
    chk("rand_drain", exp_q.size(), 0);
    read_all();

    random_run(60);
    tick(1, 8'd1, 16'd9, 0, 1, 8'd1, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tready", tready, 0);
    chk("mid_rst_ack", rd_ack, 0);
    tvalid = 1'b0;
    rd_req = 1'b0;
    init_seq();
    repeat (6) idle();
    read_all();
    repeat (4) idle();
    chk("final_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
